// File: rtl/adc_link_ctrl.sv
// JESD ADC link bring-up controller: aligner reset, CDR/CGS/data waits, retry and fail handling.
// Optional error-byte counter compiled in with `define ADC_LINK_ERR_CNT_EN.
module adc_link_ctrl #(
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 65535,
  parameter int MAX_RETRY  = 7,
  parameter int SETTLE     = 256
) (
  input  logic        clk_120,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  syncstatus,
  input  logic [7:0]  errdetect,
  input  logic [7:0]  disperr,
  input  logic        sync_n,
  input  logic [7:0]  flag_ok,
  input  logic        sysref_error,
  output logic        rst_adc_align,
  output logic        link_up,
  output logic        link_fail,
  output logic [2:0]  state,
  output logic [2:0]  retry_cnt,
  output logic [15:0] err_cnt
);

  // state     | meaning
  // IDLE      | waiting for enable, aligners held in reset
  // ALIGN_RST | pulsing aligner/LMFC/FIFO reset for RST_CYCLES
  // WAIT_CDR  | waiting for all byte lanes in sync
  // WAIT_CGS  | waiting for SYNC~ release
  // WAIT_DATA | counting consecutive clean cycles up to SETTLE
  // LINKED    | link up, monitoring for loss
  // FAIL      | retries exhausted, held until enable drops
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ALIGN_RST = 3'd1,
    S_WAIT_CDR  = 3'd2,
    S_WAIT_CGS  = 3'd3,
    S_WAIT_DATA = 3'd4,
    S_LINKED    = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  localparam logic [15:0] ALIGN_LOAD  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [2:0]  RETRY_MAX   = 3'(MAX_RETRY);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_align_tmr;
  logic [15:0] r_to_cnt;
  logic [15:0] r_settle;
  logic [2:0]  r_retry;
  logic [2:0]  w_retry_next;
  logic        w_fail_evt;
  logic        w_enter;
  logic        w_wait;
  logic        w_align_done;
  logic        w_timeout;
  logic        w_good;
  logic        w_link_lost;
  logic        w_rst_align_d;
  logic        w_link_up_d;
  logic        w_link_fail_d;
  logic        r_rst_align;
  logic        r_link_up;
  logic        r_link_fail;

  assign w_wait       = (r_state == S_WAIT_CDR) || (r_state == S_WAIT_CGS) ||
                        (r_state == S_WAIT_DATA);
  assign w_align_done = (r_align_tmr == 16'd0);
  assign w_timeout    = w_wait && (r_to_cnt == TO_LAST);
  assign w_good       = (flag_ok == 8'hFF) && (syncstatus == 8'hFF) && sync_n && !sysref_error;
  assign w_link_lost  = (syncstatus != 8'hFF) || !sync_n || sysref_error;
  assign w_enter      = (w_next != r_state);

  always_ff @(posedge clk_120) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_fail_evt   = 1'b0;
    w_retry_next = r_retry;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_ALIGN_RST;
      end
      S_ALIGN_RST: begin
        if (w_align_done) w_next = S_WAIT_CDR;
      end
      S_WAIT_CDR: begin
        if (syncstatus == 8'hFF) w_next = S_WAIT_CGS;
        else if (w_timeout)      w_fail_evt = 1'b1;
      end
      S_WAIT_CGS: begin
        if (sync_n)         w_next = S_WAIT_DATA;
        else if (w_timeout) w_fail_evt = 1'b1;
      end
      S_WAIT_DATA: begin
        // A settle completing on the last allowed cycle wins over the timeout.
        if (w_good && (r_settle == SETTLE_LAST)) w_next = S_LINKED;
        else if (w_timeout)                      w_fail_evt = 1'b1;
      end
      S_LINKED: begin
        if (w_link_lost) w_fail_evt = 1'b1;
      end
      S_FAIL: begin
        w_next = S_FAIL;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    if (w_fail_evt) begin
      if (r_retry == RETRY_MAX) begin
        w_next = S_FAIL;
      end else begin
        w_next = S_ALIGN_RST;
        if (r_retry != 3'd7) w_retry_next = r_retry + 3'd1;
      end
    end

    if (r_state == S_IDLE && enable) w_retry_next = 3'd0;

    // Dropping enable overrides everything and leaves the retry count untouched.
    if (!enable) begin
      w_next       = S_IDLE;
      w_retry_next = r_retry;
    end
  end

  always_comb begin
    w_rst_align_d = 1'b0;
    w_link_up_d   = 1'b0;
    w_link_fail_d = 1'b0;
    case (w_next)
      S_IDLE, S_ALIGN_RST: w_rst_align_d = 1'b1;
      S_LINKED:            w_link_up_d   = 1'b1;
      S_FAIL: begin
        w_rst_align_d = 1'b1;
        w_link_fail_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_120) begin
    if (rst) begin
      r_rst_align <= 1'b1;
      r_link_up   <= 1'b0;
      r_link_fail <= 1'b0;
    end else begin
      r_rst_align <= w_rst_align_d;
      r_link_up   <= w_link_up_d;
      r_link_fail <= w_link_fail_d;
    end
  end

  // All per-state counters restart whenever the state changes.
  always_ff @(posedge clk_120) begin
    if (rst) begin
      r_align_tmr <= ALIGN_LOAD;
      r_to_cnt    <= 16'd0;
      r_settle    <= 16'd0;
      r_retry     <= 3'd0;
    end else begin
      r_retry <= w_retry_next;
      if (w_enter) begin
        r_align_tmr <= ALIGN_LOAD;
        r_to_cnt    <= 16'd0;
        r_settle    <= 16'd0;
      end else begin
        if (r_state == S_ALIGN_RST && !w_align_done) r_align_tmr <= r_align_tmr - 16'd1;
        if (w_wait && r_to_cnt != 16'hFFFF)          r_to_cnt    <= r_to_cnt + 16'd1;
        if (r_state == S_WAIT_DATA)                  r_settle    <= w_good ? r_settle + 16'd1 : 16'd0;
      end
    end
  end

`ifdef ADC_LINK_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  logic [3:0]  w_err_bits;
  logic [16:0] w_err_sum;

  always_comb begin
    w_err_bits = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_err_bits = w_err_bits + {3'd0, errdetect[i] | disperr[i]};
    end
  end

  assign w_err_sum = {1'b0, r_err_cnt} + {13'd0, w_err_bits};

  always_ff @(posedge clk_120) begin
    if (rst) begin
      r_err_cnt <= 16'd0;
    end else if (w_next == S_ALIGN_RST && r_state != S_ALIGN_RST) begin
      r_err_cnt <= 16'd0;
    end else if (r_state == S_LINKED) begin
      r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_err;
  assign w_unused_err = ^{errdetect, disperr};
  assign err_cnt      = 16'h0000;
`endif

  assign state         = r_state;
  assign retry_cnt     = r_retry;
  assign rst_adc_align = r_rst_align;
  assign link_up       = r_link_up;
  assign link_fail     = r_link_fail;

endmodule
